// File: rtl/multicycle_ctrl.sv
// Multi-cycle RV32I sequencer: owns pc/ir and steps each instruction
// through FETCH, DECODE, EXEC, MEM and WB with ready-based memory handshakes.
module multicycle_ctrl #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    input  logic        imem_ready,
    input  logic [31:0] instr_rdata,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    input  logic        dmem_ready,
    input  logic [31:0] alu_rd,
    input  logic        alu_take_branch,
    input  logic [31:0] imm,
    input  logic [31:0] rs1,
    output logic [31:0] pc,
    output logic [31:0] ir,
    output logic [6:0]  opcode,
    output logic [2:0]  funct3,
    output logic        rf_we,
    output logic [1:0]  wb_sel,
    output logic        retire,
    output logic        halted,
    output logic [1:0]  cause
);

    localparam logic [2:0] S_FETCH  = 3'd0;
    localparam logic [2:0] S_DECODE = 3'd1;
    localparam logic [2:0] S_EXEC   = 3'd2;
    localparam logic [2:0] S_MEM    = 3'd3;
    localparam logic [2:0] S_WB     = 3'd4;
    localparam logic [2:0] S_HALT   = 3'd5;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_OP     = 7'b0110011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    logic [2:0]  state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] ir_q, ir_d;
    logic [31:0] alu_out_q, alu_out_d;
    logic [31:0] npc_q, npc_d;
    logic [1:0]  cause_q, cause_d;
    logic [31:0] pc_plus4;
    logic [31:0] target;
    logic        legal;
    logic        writes_rd;

    assign opcode = ir_q[6:0];
    assign funct3 = ir_q[14:12];

    always_comb begin
        legal     = 1'b0;
        writes_rd = 1'b0;
        case (opcode)
            OP_LOAD, OP_IMM, OP_OP, OP_LUI,
            OP_AUIPC, OP_JAL, OP_JALR: begin
                legal     = 1'b1;
                writes_rd = 1'b1;
            end
            OP_STORE, OP_BRANCH: legal = 1'b1;
            default: ;
        endcase
    end

    assign pc_plus4 = pc_q + 32'd4;

    always_comb begin
        case (opcode)
            OP_BRANCH: target = alu_take_branch ? pc_q + imm : pc_plus4;
            OP_JAL:    target = pc_q + imm;
            OP_JALR:   target = (rs1 + imm) & ~32'h1;
            default:   target = pc_plus4;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        ir_d      = ir_q;
        alu_out_d = alu_out_q;
        npc_d     = npc_q;
        cause_d   = cause_q;
        case (state_q)
            S_FETCH: begin
                if (imem_ready) begin
                    ir_d    = instr_rdata;
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                if (legal) begin
                    state_d = S_EXEC;
                end else if (opcode == OP_SYSTEM) begin
                    cause_d = 2'b01;
                    state_d = S_HALT;
                end else begin
                    cause_d = 2'b10;
                    state_d = S_HALT;
                end
            end
            S_EXEC: begin
                alu_out_d = alu_rd;
                npc_d     = target;
                // A misaligned target halts before any side effect.
                if (target[1:0] != 2'b00) begin
                    cause_d = 2'b11;
                    state_d = S_HALT;
                end else if (opcode == OP_LOAD || opcode == OP_STORE) begin
                    state_d = S_MEM;
                end else begin
                    state_d = S_WB;
                end
            end
            S_MEM: begin
                if (dmem_ready) state_d = S_WB;
            end
            S_WB: begin
                pc_d    = npc_q;
                state_d = S_FETCH;
            end
            default: state_d = S_HALT;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_FETCH;
            pc_q      <= RESET_PC;
            ir_q      <= 32'h0000_0013;
            alu_out_q <= 32'h0;
            npc_q     <= RESET_PC;
            cause_q   <= 2'b00;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            ir_q      <= ir_d;
            alu_out_q <= alu_out_d;
            npc_q     <= npc_d;
            cause_q   <= cause_d;
        end
    end

    // State resets to FETCH, so gate the fetch request while reset is held.
    assign imem_req  = rst_n && (state_q == S_FETCH);
    assign dmem_req  = (state_q == S_MEM);
    assign dmem_we   = dmem_req && (opcode == OP_STORE);
    assign dmem_addr = alu_out_q;
    assign retire    = (state_q == S_WB);
    assign rf_we     = retire && writes_rd && (ir_q[11:7] != 5'd0);
    assign halted    = (state_q == S_HALT);
    assign cause     = cause_q;
    assign pc        = pc_q;
    assign ir        = ir_q;

    always_comb begin
        case (opcode)
            OP_LOAD:         wb_sel = 2'b01;
            OP_JAL, OP_JALR: wb_sel = 2'b10;
            OP_AUIPC:        wb_sel = 2'b11;
            default:         wb_sel = 2'b00;
        endcase
    end

endmodule

// File: doc/multicycle_ctrl.md
# multicycle_ctrl

Multi-cycle sequencer for the RV32I core. It owns the PC and the instruction register, and steps each instruction through fetch, decode, execute, memory and writeback. It drives the ALU's opcode/funct3, chooses the register-file writeback source, and runs ready-based handshakes to instruction and data memory. It also computes the next PC and halts on SYSTEM, illegal or misaligned-target events.

## Interface
- RESET_PC, 32'h0000_0000, PC value loaded on reset

- clk  in  1  rising-edge clock
- rst_n  in  1  reset; one clock; reset is asynchronous and active-low
- imem_req  out  1  instruction fetch request at address pc
- imem_ready  in  1  instruction valid on instr_rdata this cycle
- instr_rdata  in  32  fetched instruction
- dmem_req  out  1  data access request
- dmem_we  out  1  1 = store, 0 = load (valid while dmem_req)
- dmem_addr  out  32  registered ALU result
- dmem_ready  in  1  data access complete this cycle
- alu_rd  in  32  ALU result
- alu_take_branch  in  1  branch condition from ALU
- imm  in  32  decoded immediate for ir
- rs1  in  32  register-file read port 1
- pc  out  32  current instruction address
- ir  out  32  latched instruction
- opcode  out  7  ir[6:0]
- funct3  out  3  ir[14:12]
- rf_we  out  1  register-file write strobe (one cycle)
- wb_sel  out  2  00 alu_out, 01 load data, 10 pc+4, 11 pc+imm
- retire  out  1  one-cycle pulse per completed instruction
- halted  out  1  sticky; core stopped
- cause  out  2  00 none, 01 ECALL/EBREAK, 10 illegal opcode, 11 misaligned target

## Operation
- States are FETCH, DECODE, EXEC, MEM, WB and HALT.
- **FETCH**: imem_req=1 and pc stable. On imem_ready, ir<=instr_rdata and the state goes to DECODE. With no ready, the state holds indefinitely.
- **DECODE**: one cycle; operands settle.
  - Legal opcodes are 0000011, 0100011, 0010011, 0110011, 0110111, 0010111, 1101111, 1100111 and 1100011. These go to EXEC.
  - Opcode 1110011 sets cause=01 and goes to HALT.
  - Any other opcode sets cause=10 and goes to HALT.
- **EXEC**: one cycle.
  - alu_out<=alu_rd and br<=alu_take_branch.
  - next_pc is computed:
    - BRANCH: pc+imm if alu_take_branch, else pc+4.
    - JAL: pc+imm.
    - JALR: (rs1+imm)&~1.
    - All others: pc+4.
  - If next_pc[1:0]!=0, cause=11 and go to HALT; no writeback or memory access occurs.
  - LOAD/STORE go to MEM; all other opcodes go to WB.
- **MEM**: dmem_req=1, dmem_we=(opcode==STORE), dmem_addr=alu_out. On dmem_ready, go to WB; with no ready, hold.
- **WB**: one cycle.
  - pc<=next_pc and retire=1.
  - rf_we=1 only for LOAD, OP_IMM, OP, LUI, AUIPC, JAL and JALR, and only when ir[11:7]!=0.
  - wb_sel is:
    - LOAD: 01.
    - JAL/JALR: 10.
    - AUIPC: 11.
    - All others: 00.
  - Next state is FETCH.
- **HALT**: all strobes 0, halted=1, and pc/ir/cause frozen. Only rst_n exits.
- All arithmetic is 32-bit modulo 2^32; pc wraps from 32'hFFFF_FFFC to 0.

## Timing
- Reset values: pc=RESET_PC, ir=32'h0000_0013, state FETCH, alu_out=0, halted=0, cause=00.
  - All strobes (imem_req, dmem_req, dmem_we, rf_we, retire) are 0 during reset.
  - imem_req rises in the first cycle after rst_n deasserts.
- Assertion mid-operation aborts immediately and asynchronously: requests drop, and no rf_we or retire is issued.
- Latency with zero-wait memory (ready in the same cycle as req):
  - ALU, LUI, AUIPC, jump, branch: 4 cycles.
  - Load, store: 5 cycles.
  - Each wait cycle adds 1.
- Handshake:
  - The request stays high and its address/we stay stable until ready is sampled high.
  - Exactly one transfer per request.
  - A ready sampled while the request is low is ignored.
- rf_we and retire are high together for exactly one cycle (the WB cycle). pc updates on the clock edge that ends WB.
- opcode and funct3 are combinational from ir and valid from DECODE onward.

## Test plan
- **ADDI, zero-wait**: instr 32'h0050_0093 (addi x1,x0,5), alu_rd=5, imem_ready tied 1 -> retire 4 cycles after reset release; rf_we with wb_sel=00; pc 0->4.
- **Load with waits**: lw, alu_rd=32'h100, dmem_ready after 3 wait cycles -> dmem_req high 4 cycles with dmem_addr=32'h100 and dmem_we=0; rf_we with wb_sel=01; total 8 cycles.
- **Branches**: beq with imm=-8 at pc=32'h20.
  - alu_take_branch=1 -> pc=32'h18.
  - alu_take_branch=0 -> pc=32'h24.
  - Either case: no rf_we.
- **JALR and x0 destination**: rs1=32'h103, imm=0 -> pc=32'h102. This target is misaligned, so expect halted=1, cause=11, no retire. Separately, jal with rd=x0 -> retire with rf_we=0.
- **Halts**:
  - Instr 32'h0000_0073 -> halted, cause=01, imem_req stays 0 for the rest of the test.
  - Instr 32'hFFFF_FFFF -> halted, cause=10.
- **Reset mid-MEM**: rst_n low during a store wait -> dmem_req drops asynchronously; pc=RESET_PC; refetch starts after release.
